// File: rtl/risc_pkg.sv
// Shared constants, opcode encoding and instruction field positions for the RISC execution core.
package risc_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_NOT   = 4'd6,
        OP_LOAD  = 4'd7,
        OP_STORE = 4'd8
    } opcode_e;

    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned RS1_LSB = 9;
    localparam int unsigned RS2_LSB = 6;
    localparam int unsigned RD_LSB  = 3;

endpackage

// File: rtl/register_file.sv
// Register file: two combinational read ports, one synchronous write port, synchronous clear.
module register_file
    import risc_pkg::*;
#(
    parameter int unsigned Width = DATA_W,
    parameter int unsigned Depth = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [AddrW-1:0] raddr_a_i,
    output logic [Width-1:0] rdata_a_o,
    input  logic [AddrW-1:0] raddr_b_i,
    output logic [Width-1:0] rdata_b_o,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i
);

    logic [Width-1:0] registers [0:Depth-1];

    assign rdata_a_o = registers[raddr_a_i];
    assign rdata_b_o = registers[raddr_b_i];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                registers[i] <= '0;
            end
        end else if (we_i) begin
            registers[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/risc_processor.sv
// Single-cycle 16-bit RISC execution core: register file, ALU and data memory.
// Optional RISC_FLAGS_EN adds registered zero_flag/carry_flag outputs.
module risc_processor #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instruction,
    output logic [DATA_W-1:0] result
`ifdef RISC_FLAGS_EN
    ,
    output logic              zero_flag,
    output logic              carry_flag
`endif
);

    import risc_pkg::*;

    localparam int unsigned RegAddrW = $clog2(NUM_REGS);
    localparam int unsigned MemAddrW = $clog2(DMEM_DEPTH);

    logic [OPC_W-1:0]    opcode;
    logic [RegAddrW-1:0] rs1;
    logic [RegAddrW-1:0] rs2;
    logic [RegAddrW-1:0] rd;
    logic [DATA_W-1:0]   rs1_data;
    logic [DATA_W-1:0]   rs2_data;
    logic [MemAddrW-1:0] mem_addr;
    logic [DATA_W:0]     sum_w;
    logic [DATA_W:0]     diff_w;

    logic [DATA_W-1:0]   wb_data;
    logic                reg_we;
    logic                mem_we;
    logic                res_upd;
    logic                carry_d;

    logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
    logic [DATA_W-1:0]   result_q;

    assign opcode   = instruction[OPC_LSB +: OPC_W];
    assign rs1      = instruction[RS1_LSB +: RegAddrW];
    assign rs2      = instruction[RS2_LSB +: RegAddrW];
    assign rd       = instruction[RD_LSB +: RegAddrW];
    // Upper address bits are dropped so addresses wrap around the memory.
    assign mem_addr = rs1_data[MemAddrW-1:0];

    register_file #(
        .Width (DATA_W),
        .Depth (NUM_REGS)
    ) rf (
        .clk_i     (clk),
        .rst_ni    (rst),
        .raddr_a_i (rs1),
        .rdata_a_o (rs1_data),
        .raddr_b_i (rs2),
        .rdata_b_o (rs2_data),
        .we_i      (reg_we),
        .waddr_i   (rd),
        .wdata_i   (wb_data)
    );

    // Bit DATA_W carries out of ADD and flags the borrow of SUB.
    assign sum_w  = {1'b0, rs1_data} + {1'b0, rs2_data};
    assign diff_w = {1'b0, rs1_data} - {1'b0, rs2_data};

    always_comb begin
        wb_data = '0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        carry_d = 1'b0;
        case (opcode)
            OP_ADD: begin
                wb_data = sum_w[DATA_W-1:0];
                carry_d = sum_w[DATA_W];
                reg_we  = 1'b1;
            end
            OP_SUB: begin
                wb_data = diff_w[DATA_W-1:0];
                carry_d = diff_w[DATA_W];
                reg_we  = 1'b1;
            end
            OP_AND: begin
                wb_data = rs1_data & rs2_data;
                reg_we  = 1'b1;
            end
            OP_OR: begin
                wb_data = rs1_data | rs2_data;
                reg_we  = 1'b1;
            end
            OP_XOR: begin
                wb_data = rs1_data ^ rs2_data;
                reg_we  = 1'b1;
            end
            OP_NOT: begin
                wb_data = ~rs1_data;
                reg_we  = 1'b1;
            end
            OP_LOAD: begin
                wb_data = dmem[mem_addr];
                reg_we  = 1'b1;
            end
            OP_STORE: begin
                wb_data = rs2_data;
                mem_we  = 1'b1;
            end
            default: begin
            end
        endcase
        res_upd = reg_we | mem_we;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else begin
            if (res_upd) begin
                result_q <= wb_data;
            end
            if (mem_we) begin
                dmem[mem_addr] <= rs2_data;
            end
        end
    end

    assign result = result_q;

`ifdef RISC_FLAGS_EN
    logic zero_q;
    logic carry_q;

    // Flags follow register-writing ops only; NOP and STORE leave them alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (reg_we) begin
            zero_q  <= (wb_data == '0);
            carry_q <= carry_d;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
`else
    logic unused_carry;
    assign unused_carry = carry_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{instruction[2:0], rs1_data[DATA_W-1:MemAddrW]};

endmodule

// File: tb/tb_risc_processor.sv
// Scoreboard bench for risc_processor: directed instructions push expectations, a monitor checks.
module tb_risc_processor;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] result;
    logic        zero_flag;
    logic        carry_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] res;
        bit          chk_reg;
        int          ridx;
        logic [15:0] rval;
        bit          all_zero;
        bit          z;
        bit          c;
    } exp_t;

    exp_t sb[$];

`ifdef RISC_FLAGS_EN
    risc_processor dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .result      (result),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag)
    );
`else
    risc_processor dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .result      (result)
    );
    assign zero_flag  = 1'b0;
    assign carry_flag = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [3:0] op, input int s1, input int s2,
                                        input int d);
        logic [2:0] a = 3'(s1);
        logic [2:0] b = 3'(s2);
        logic [2:0] r = 3'(d);
        return {op, a, b, r, 3'b000};
    endfunction

    function automatic exp_t mk(input string name, input logic [15:0] res, input bit chk_reg,
                                input int ridx, input logic [15:0] rval, input bit z,
                                input bit c);
        exp_t e;
        e.name     = name;
        e.res      = res;
        e.chk_reg  = chk_reg;
        e.ridx     = ridx;
        e.rval     = rval;
        e.all_zero = 1'b0;
        e.z        = z;
        e.c        = c;
        return e;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] ins, input exp_t e);
        @(negedge clk);
        rst         = 1'b1;
        instruction = ins;
        sb.push_back(e);
    endtask

    task automatic apply_reset(input string name, input logic [15:0] ins);
        exp_t e;
        e = mk(name, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        e.all_zero = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        instruction = ins;
        sb.push_back(e);
    endtask

    // Backdoor preload happens while a NOP is presented, so no write-back competes.
    task automatic preload(input int idx, input logic [15:0] val);
        @(negedge clk);
        rst         = 1'b1;
        instruction = 16'h0000;
        dut.rf.registers[idx] = val;
    endtask

    // Monitor: every instruction yields a result one edge later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check16({e.name, ".result"}, result, e.res);
                if (e.chk_reg) begin
                    check16($sformatf("%s.R%0d", e.name, e.ridx), dut.rf.registers[e.ridx],
                            e.rval);
                end
                if (e.all_zero) begin
                    for (int i = 0; i < 8; i++) begin
                        check16($sformatf("%s.R%0d", e.name, i), dut.rf.registers[i], 16'h0000);
                    end
                end
`ifdef RISC_FLAGS_EN
                check16({e.name, ".zero"}, {15'h0, zero_flag}, {15'h0, e.z});
                check16({e.name, ".carry"}, {15'h0, carry_flag}, {15'h0, e.c});
`endif
            end
        end
    end

    initial begin
        rst         = 1'b0;
        instruction = 16'h0000;

        apply_reset("reset", 16'h0000);
        for (int i = 0; i < 8; i++) preload(i, 16'(i + 1));

        issue(enc(4'b0001, 0, 1, 2), mk("add", 16'h0003, 1, 2, 16'h0003, 0, 0));
        issue(enc(4'b0010, 2, 1, 3), mk("sub", 16'h0001, 1, 3, 16'h0001, 0, 0));
        issue(enc(4'b0011, 3, 0, 4), mk("and", 16'h0001, 1, 4, 16'h0001, 0, 0));
        issue(enc(4'b0100, 4, 3, 5), mk("or", 16'h0001, 1, 5, 16'h0001, 0, 0));
        issue(enc(4'b0101, 5, 4, 6), mk("xor", 16'h0000, 1, 6, 16'h0000, 1, 0));
        issue(enc(4'b0110, 6, 0, 7), mk("not", 16'hFFFF, 1, 7, 16'hFFFF, 0, 0));

        preload(0, 16'h0005);
        preload(1, 16'hABCD);
        preload(6, 16'h0105);
        issue(enc(4'b1000, 0, 1, 3), mk("store", 16'hABCD, 1, 3, 16'h0001, 0, 0));
        issue(enc(4'b0111, 0, 0, 3), mk("load", 16'hABCD, 1, 3, 16'hABCD, 0, 0));
        issue(enc(4'b0111, 2, 0, 4), mk("load_empty", 16'h0000, 1, 4, 16'h0000, 1, 0));
        issue(enc(4'b0111, 6, 0, 5), mk("load_wrap", 16'hABCD, 1, 5, 16'hABCD, 0, 0));

        preload(0, 16'h0001);
        preload(1, 16'h0002);
        issue(enc(4'b0010, 0, 1, 2), mk("sub_wrap", 16'hFFFF, 1, 2, 16'hFFFF, 0, 1));
        issue(enc(4'b0001, 2, 0, 3), mk("add_carry", 16'h0000, 1, 3, 16'h0000, 1, 1));
        issue(enc(4'b0001, 1, 1, 1), mk("add_self", 16'h0004, 1, 1, 16'h0004, 0, 0));
        issue(enc(4'b0000, 1, 1, 1), mk("nop", 16'h0004, 1, 1, 16'h0004, 0, 0));
        issue(enc(4'b1111, 1, 1, 1), mk("undef", 16'h0004, 1, 1, 16'h0004, 0, 0));

        apply_reset("mid_reset", enc(4'b0001, 1, 1, 1));
        preload(0, 16'h0005);
        issue(enc(4'b0111, 0, 0, 1), mk("load_cleared", 16'h0000, 1, 1, 16'h0000, 1, 0));
        issue(enc(4'b0001, 0, 0, 2), mk("add_after_rst", 16'h000A, 1, 2, 16'h000A, 0, 0));

        @(negedge clk);
        instruction = 16'h0000;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_processor.md
Name: risc_processor

Overview:
- 16-bit single-issue RISC datapath with an externally supplied instruction each cycle; there is no internal fetch or program counter.
- Contains an 8x16 register file, an ALU and a small data memory.
- Each instruction executes in one clock: the register write-back and the registered `result` output update on the same rising edge.
- Serves as the execution core of the RISC test system.

Parameters:
- DATA_W, 16, datapath/register width
- NUM_REGS, 8, register file entries (3-bit specifiers)
- DMEM_DEPTH, 256, data memory words (addressed by low log2(DMEM_DEPTH) bits)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-low reset
- instruction  input  16  instruction to execute this cycle
- result  output  16  registered value produced by the last executed instruction

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-low: sampled on the rising edge, asserted when 0.
- Reset clears all registers, all data memory words and `result` to 16'h0000.
- Instruction format:
  - [15:12] opcode
  - [11:9] rs1
  - [8:6] rs2
  - [5:3] rd
  - [2:0] reserved, ignored
- Operands R[rs1] and R[rs2] are read combinationally from the register file.
- Opcodes:
  - 0000 NOP: no write; `result` holds.
  - 0001 ADD: rd = rs1 + rs2, modulo 2^16, carry dropped.
  - 0010 SUB: rd = rs1 - rs2, modulo 2^16, wraps (1-2 = FFFF).
  - 0011 AND: rd = rs1 & rs2.
  - 0100 OR: rd = rs1 | rs2.
  - 0101 XOR: rd = rs1 ^ rs2.
  - 0110 NOT: rd = ~rs1; rs2 ignored.
  - 0111 LOAD: rd = DMEM[R[rs1]]; `result` = loaded word.
  - 1000 STORE: DMEM[R[rs1]] = R[rs2]; no register write; `result` = stored word.
  - 1001-1111: treated as NOP.
- Latency is 1 cycle. On a rising edge with rst=1, both R[rd] and `result` take the new value. The written value is visible to the next instruction, so back-to-back dependencies need no stalls.
- rd equal to rs1/rs2 is allowed: operands are read before the edge, and the new value is written at the edge.
- Register 0 is an ordinary writable register, not hard-wired to zero.
- Memory address uses the low 8 bits of R[rs1] (for DMEM_DEPTH=256); upper bits are ignored, so addresses wrap.
- The register file array must be reachable as instance `rf`, array `registers[0:7]`, so benches can preload it hierarchically.
- Reset asserted mid-stream overrides any instruction on that edge.

Optional Feature:
- Macro RISC_FLAGS_EN.
- When defined:
  - Adds output ports `zero_flag` (1 bit) and `carry_flag` (1 bit), registered alongside `result`.
  - zero_flag = (result value == 0) for ALU/LOAD ops.
  - carry_flag = carry out of ADD, or borrow of SUB; cleared by other ALU ops.
  - NOP and STORE leave both flags unchanged.
  - Both flags reset to 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package risc_pkg:
  - DATA_W and REG_ADDR_W constants
  - opcode enum (OP_NOP … OP_STORE)
  - instruction field slice positions
- Sub-module register_file, instanced as `rf`:
  - 2 combinational read ports, 1 synchronous write port, synchronous active-low clear
  - array named `registers`
- ALU and data memory live inline in risc_processor.

Test Plan:
- Reset: hold rst=0 for one edge, then release; expect `result`=0000 and all R=0000. Then preload R0..R7 = 1..8.
- ADD 0001_000_001_010_000 -> result 0003, R2=0003. Then SUB 0010_010_001_011_000 -> result 0001, R3=0001.
- AND 0011_011_000_100_000 -> 0001; OR 0100_100_011_101_000 -> 0001; XOR 0101_101_100_110_000 -> 0000; NOT 0110_110_000_111_000 -> FFFF, R7=FFFF.
- STORE R[rs1]=0005, R[rs2]=ABCD -> result ABCD. Then LOAD from the same address into R3 -> result ABCD, R3=ABCD. LOAD from an unwritten address -> 0000.
- Wrap and dependency: SUB with R0=0001, R1=0002 -> FFFF. Then ADD FFFF+0001 -> 0000 (carry_flag=1, zero_flag=1 under RISC_FLAGS_EN).
- NOP/undefined opcode 1111 -> result and all registers unchanged. Assert rst=0 mid-sequence -> next edge clears everything.
